// File: rtl/sram_controller.sv
// Serves 32-bit MEM-stage loads/stores from a 16-bit asynchronous SRAM as two
// halfword phases of SRAM_WAIT cycles each; ready drops while a request is in flight.
module sram_controller #(
  parameter int unsigned SRAM_WAIT = 2,
  parameter logic [31:0] BASE_ADDR = 32'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic [17:0] sram_addr,
  output logic        sram_we_n,
  output logic [15:0] sram_dq_out,
  output logic        sram_dq_oe,
  input  logic [15:0] sram_dq_in
);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  localparam logic [3:0] CNT_LAST = 4'(SRAM_WAIT - 1);

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        req;
  logic        last;
  logic [31:0] offset;

  logic [16:0] word_p0;
  logic [31:0] data_p0;
  logic        op_wr_p0;
  logic [15:0] low_p1;
  logic [15:0] dq_hold;

  assign req    = wr_en | rd_en;
  assign last   = (cnt == CNT_LAST);
  // Subtraction wraps modulo 2^32 before the word field is taken.
  assign offset = address - BASE_ADDR;
  assign ready  = rst | ~(req & (state != DONE));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      read_data <= '0;
      dq_hold   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (state == HIGH && last && !op_wr_p0)
        read_data <= {sram_dq_in, low_p1};
      if (state == LOW || state == HIGH)
        dq_hold <= sram_dq_out;
    end
  end

  // Request capture stage: inputs are sampled only when leaving IDLE.
  always_ff @(posedge clk) begin
    if (state == IDLE && req) begin
      word_p0  <= offset[18:2];
      data_p0  <= write_data;
      op_wr_p0 <= wr_en;
    end
    if (state == LOW && last && !op_wr_p0)
      low_p1 <= sram_dq_in;
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (req) begin
          state_nxt = LOW;
          cnt_nxt   = '0;
        end
      end
      LOW: begin
        if (last) begin
          state_nxt = HIGH;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      HIGH: begin
        if (last) begin
          state_nxt = DONE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // SRAM pin stage: strobes and address are only active inside a phase.
  always_comb begin
    sram_addr   = '0;
    sram_we_n   = 1'b1;
    sram_dq_oe  = 1'b0;
    sram_dq_out = dq_hold;
    case (state)
      LOW: begin
        sram_addr   = {word_p0, 1'b0};
        sram_dq_out = data_p0[15:0];
        sram_dq_oe  = op_wr_p0;
        sram_we_n   = ~op_wr_p0;
      end
      HIGH: begin
        sram_addr   = {word_p0, 1'b1};
        sram_dq_out = data_p0[31:16];
        sram_dq_oe  = op_wr_p0;
        sram_we_n   = ~op_wr_p0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: directed vector table, reset abort, and random
// traffic checked against a word-level memory model.
module tb_sram_controller;

  localparam int W    = 2;
  localparam int NCYC = 2 * W + 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic        sram_we_n;
  logic [15:0] sram_dq_out;
  logic        sram_dq_oe;
  logic [15:0] sram_dq_in = 16'h0;

  sram_controller #(.SRAM_WAIT(W), .BASE_ADDR(32'd1024)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en),
    .address(address), .write_data(write_data), .read_data(read_data),
    .ready(ready), .sram_addr(sram_addr), .sram_we_n(sram_we_n),
    .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe), .sram_dq_in(sram_dq_in)
  );

  always #5 clk = ~clk;

  // Asynchronous SRAM: writes land while we_n is low, reads settle mid-cycle.
  bit [15:0] sram_mem [0:262143];
  always @(posedge clk) if (!sram_we_n) sram_mem[sram_addr] <= sram_dq_out;
  always @(negedge clk) sram_dq_in <= sram_mem[sram_addr];

  int n_chk;
  int n_fail;

  logic        rec_rdy  [0:NCYC-1];
  logic [17:0] rec_addr [0:NCYC-1];
  logic        rec_we   [0:NCYC-1];
  logic        rec_oe   [0:NCYC-1];
  logic [15:0] rec_dq   [0:NCYC-1];
  logic [31:0] rec_rdata;

  logic [31:0] ref_mem [int];
  logic [31:0] cur_rd;

  typedef struct {
    bit          wr;
    bit          rd;
    logic [31:0] addr;
    logic [31:0] data;
    int          drop;
    logic [17:0] lo_addr;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vt [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Starts at posedge+1 with the DUT idle; ends at posedge+1 after DONE.
  task automatic run_txn(input bit wr, input bit rd, input logic [31:0] a,
                         input logic [31:0] d, input int drop);
    wr_en = wr; rd_en = rd; address = a; write_data = d;
    for (int c = 0; c < NCYC; c++) begin
      if (c == drop) begin wr_en = 1'b0; rd_en = 1'b0; end
      @(negedge clk);
      rec_rdy[c]  = ready;
      rec_addr[c] = sram_addr;
      rec_we[c]   = sram_we_n;
      rec_oe[c]   = sram_dq_oe;
      rec_dq[c]   = sram_dq_out;
      if (c == NCYC - 1) rec_rdata = read_data;
      @(posedge clk); #1;
    end
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic check_txn(input string tag, input bit wr, input logic [31:0] d,
                           input int drop, input logic [17:0] lo,
                           input logic [31:0] exp_rd);
    for (int c = 0; c < NCYC; c++) begin
      bit in_lo, in_hi, act, exp_rdy;
      in_lo   = (c >= 1) && (c <= W);
      in_hi   = (c > W) && (c <= 2 * W);
      act     = in_lo || in_hi;
      exp_rdy = (c == NCYC - 1) || (drop > 0 && c >= drop);
      chk($sformatf("%s.c%0d.ready", tag, c), 32'(rec_rdy[c]), 32'(exp_rdy));
      chk($sformatf("%s.c%0d.addr", tag, c), 32'(rec_addr[c]),
          in_lo ? 32'(lo) : in_hi ? 32'(lo) + 32'd1 : 32'd0);
      chk($sformatf("%s.c%0d.we_n", tag, c), 32'(rec_we[c]), 32'(!(act && wr)));
      chk($sformatf("%s.c%0d.oe", tag, c), 32'(rec_oe[c]), 32'(act && wr));
      if (act && wr)
        chk($sformatf("%s.c%0d.dq", tag, c), 32'(rec_dq[c]),
            in_lo ? 32'(d[15:0]) : 32'(d[31:16]));
    end
    chk($sformatf("%s.read_data", tag), rec_rdata, exp_rd);
  endtask

  function automatic int word_of(input logic [31:0] a);
    logic [31:0] off;
    off = a - 32'd1024;
    return int'(off[18:2]);
  endfunction

  initial begin
    n_chk = 0; n_fail = 0;
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; address = '0; write_data = '0;
    cur_rd = '0;

    vt[0]  = '{1, 0, 32'd1028,    32'hDEADBEEF, -1, 18'd2,       32'h0};
    vt[1]  = '{0, 1, 32'd1028,    32'h0,        -1, 18'd2,       32'hDEADBEEF};
    vt[2]  = '{1, 0, 32'd1024,    32'h12345678, -1, 18'd0,       32'hDEADBEEF};
    vt[3]  = '{0, 1, 32'd1024,    32'h0,        -1, 18'd0,       32'h12345678};
    vt[4]  = '{1, 1, 32'd1032,    32'hCAFEF00D, -1, 18'd4,       32'h12345678};
    vt[5]  = '{0, 1, 32'd1032,    32'h0,        -1, 18'd4,       32'hCAFEF00D};
    vt[6]  = '{0, 1, 32'd1029,    32'h0,         2, 18'd2,       32'hDEADBEEF};
    vt[7]  = '{1, 0, 32'h000803FC, 32'hA5A55A5A, -1, 18'h3FFFE,  32'hDEADBEEF};
    vt[8]  = '{1, 0, 32'd1020,    32'h11112222, -1, 18'h3FFFE,   32'hDEADBEEF};
    vt[9]  = '{0, 1, 32'h000803FC, 32'h0,        -1, 18'h3FFFE,  32'h11112222};
    vt[10] = '{0, 1, 32'h0,       32'h0,        -1, 18'h3FE00,   32'h0};

    // Reset held three cycles, then released.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk($sformatf("rst%0d.ready", i), 32'(ready), 32'd1);
      chk($sformatf("rst%0d.we_n", i), 32'(sram_we_n), 32'd1);
      chk($sformatf("rst%0d.oe", i), 32'(sram_dq_oe), 32'd0);
      chk($sformatf("rst%0d.addr", i), 32'(sram_addr), 32'd0);
      chk($sformatf("rst%0d.dq", i), 32'(sram_dq_out), 32'd0);
      chk($sformatf("rst%0d.read_data", i), read_data, 32'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("idle.ready", 32'(ready), 32'd1);
    chk("idle.we_n", 32'(sram_we_n), 32'd1);
    chk("idle.oe", 32'(sram_dq_oe), 32'd0);
    chk("idle.read_data", read_data, 32'd0);
    @(posedge clk); #1;

    // Directed table, issued back-to-back.
    for (int i = 0; i < 11; i++) begin
      run_txn(vt[i].wr, vt[i].rd, vt[i].addr, vt[i].data, vt[i].drop);
      check_txn($sformatf("vec%0d", i), vt[i].wr, vt[i].data, vt[i].drop,
                vt[i].lo_addr, vt[i].exp_rd);
      if (vt[i].wr) ref_mem[word_of(vt[i].addr)] = vt[i].data;
      else cur_rd = vt[i].exp_rd;
    end

    // Reset pulsed during the high phase of a write to an otherwise unused word.
    wr_en = 1'b1; rd_en = 1'b0; address = 32'd1024 + 32'd400; write_data = 32'h0BADF00D;
    repeat (W + 1) begin @(posedge clk); #1; end
    @(negedge clk);
    chk("abort.high.we_n", 32'(sram_we_n), 32'd0);
    chk("abort.high.addr", 32'(sram_addr), 32'd201);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("abort.rst.ready", 32'(ready), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0; wr_en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk($sformatf("abort.after%0d.we_n", i), 32'(sram_we_n), 32'd1);
      chk($sformatf("abort.after%0d.oe", i), 32'(sram_dq_oe), 32'd0);
      chk($sformatf("abort.after%0d.addr", i), 32'(sram_addr), 32'd0);
      chk($sformatf("abort.after%0d.ready", i), 32'(ready), 32'd1);
      chk($sformatf("abort.after%0d.read_data", i), read_data, 32'd0);
      @(posedge clk); #1;
    end
    cur_rd = '0;

    // Random traffic against the word-level model.
    for (int t = 0; t < 40; t++) begin
      bit          wr, rd;
      int          word, drop, gap;
      logic [31:0] a, d, exp_rd;
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        chk($sformatf("rnd%0d.gap.ready", t), 32'(ready), 32'd1);
        chk($sformatf("rnd%0d.gap.we_n", t), 32'(sram_we_n), 32'd1);
        @(posedge clk); #1;
      end
      wr   = bit'($urandom & 1);
      rd   = wr ? bit'($urandom & 1) : 1'b1;
      word = int'($urandom_range(0, 15));
      a    = 32'd1024 + 32'(word * 4) + 32'($urandom_range(0, 3));
      d    = $urandom;
      drop = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2 * W)) : -1;
      if (wr) exp_rd = cur_rd;
      else    exp_rd = ref_mem.exists(word) ? ref_mem[word] : 32'h0;
      run_txn(wr, rd, a, d, drop);
      check_txn($sformatf("rnd%0d", t), wr, d, drop, 18'(word * 2), exp_rd);
      if (wr) ref_mem[word] = d;
      else    cur_rd = exp_rd;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_controller.md
# sram_controller

Multi-cycle memory responder that serves the MEM stage's load/store requests (`MEM_R_EN`/`MEM_W_EN`, address, `val_Rm` store data) from an external 16-bit asynchronous SRAM. Each 32-bit access is split into two halfword phases of `SRAM_WAIT` cycles each. While a request is in progress the block drops `ready`, and the pipeline derives its freeze from that signal. It sits between the MEM stage and the board SRAM pins, replacing the single-cycle data memory.

## Interface
Parameters:
- `SRAM_WAIT`, default 2, cycles per halfword phase (legal range 1..15)
- `BASE_ADDR`, default 1024, byte address mapped to SRAM word 0

Ports:
- `clk` in 1: single clock, rising edge
- `rst` in 1: synchronous, active-high reset
- `wr_en` in 1: store request from MEM stage
- `rd_en` in 1: load request from MEM stage
- `address` in 32: byte address from MEM stage
- `write_data` in 32: store data (`val_Rm`)
- `read_data` out 32: load result; held until the next read completes
- `ready` out 1: 0 while a request is outstanding and not yet complete (pipeline freeze = ~ready)
- `sram_addr` out 18: SRAM halfword address
- `sram_we_n` out 1: SRAM write strobe, active low
- `sram_dq_out` out 16: halfword driven to SRAM
- `sram_dq_oe` out 1: 1 = drive `sram_dq_out` onto the pad (tristate control lives at the pad)
- `sram_dq_in` in 16: halfword read from SRAM

## Operation
- Address map:
  - word = (`address` − `BASE_ADDR`)[18:2], a 17-bit field, so the subtraction wraps modulo 2^32.
  - Low halfword at `sram_addr` = {word, 0}; high halfword at {word, 1}.
- FSM states: IDLE, LOW, HIGH, DONE. A phase counter counts 0..`SRAM_WAIT`−1.
- IDLE:
  - If `wr_en | rd_en`: latch `address`, `write_data` and op (write has priority if both are set), clear the counter, go to LOW.
  - Otherwise stay in IDLE.
- LOW:
  - `sram_addr` = {word, 0}.
  - Write: `sram_dq_out` = data[15:0], `sram_dq_oe` = 1, `sram_we_n` = 0.
  - Read: `sram_we_n` = 1, `sram_dq_oe` = 0. On the last counter cycle, capture `sram_dq_in` into an internal low register.
  - On the last counter cycle, clear the counter and go to HIGH.
- HIGH:
  - Same as LOW, using {word, 1} and data[31:16].
  - Read: on the last cycle, `read_data` ← {`sram_dq_in`, low register}.
  - Then go to DONE.
- DONE: one cycle with `ready` = 1 so the pipeline advances, then go to IDLE unconditionally.
- `ready` is combinational: `rst` | ~((`wr_en` | `rd_en`) & state != DONE). With no request, `ready` = 1 in every state.
- Once started, a transaction always runs to DONE, even if `rd_en`/`wr_en` drop (for example on a flush). Inputs are not re-sampled mid-transaction.
- Outside LOW/HIGH:
  - `sram_we_n` = 1, `sram_dq_oe` = 0, `sram_addr` = 0.
  - `sram_dq_out` holds its last value (don't-care).

## Timing
- Reset values:
  - State IDLE, counter 0, `read_data` = 0.
  - `sram_we_n` = 1, `sram_dq_oe` = 0, `sram_addr` = 0, `sram_dq_out` = 0.
  - `ready` = 1 while `rst` is high.
- Latency, with the request first seen in IDLE at cycle 0:
  - LOW: cycles 1..W.
  - HIGH: cycles W+1..2W.
  - DONE: cycle 2W+1, where `ready` rises.
  - With W = 2, `ready` is low for cycles 0–4 and high at cycle 5.
- `read_data` is valid from the DONE cycle onward and is registered at the HIGH→DONE edge.
- Back-to-back requests: the cycle after DONE is IDLE. A request present then starts immediately, so `ready` goes low again in that same cycle.
- `rst` asserted mid-transaction:
  - Next edge forces IDLE and strobes inactive.
  - The partial SRAM write is abandoned.
  - `read_data` is cleared.
- Write strobe: `sram_we_n` stays low for all W cycles of a phase, with address and data stable throughout.

## Test plan
- Reset then idle: hold `rst` 3 cycles → `ready` = 1, `sram_we_n` = 1, `sram_dq_oe` = 0, `read_data` = 0 throughout and after release.
- Store: `wr_en` = 1, `address` = 1028, `write_data` = 0xDEADBEEF, W = 2 → `sram_addr` = 2 with dq 0xBEEF for 2 cycles, then 3 with 0xDEAD for 2 cycles. `ready` is low for 5 cycles and high on the 6th.
- Load: SRAM model holds 0xBEEF at address 2 and 0xDEAD at address 3; `rd_en` = 1, `address` = 1028 → `read_data` = 0xDEADBEEF at DONE, with `sram_we_n` = 1 throughout.
- Back-to-back: a store to 1024 followed immediately by a load from 1024 → the load returns the stored value, and `ready` is high for exactly one cycle between the two transactions.
- Abort and priority:
  - `rst` pulsed during the HIGH phase of a write → IDLE next cycle and `sram_we_n` = 1.
  - `rd_en` = `wr_en` = 1 → a write is performed.
- Dropped request: `rd_en` deasserted in cycle 2 of a read → the transaction still reaches DONE, `ready` = 1 from cycle 2 onward, and `read_data` is updated.
